mod_addsub_pipe: RTL and testbench
==================================

# mod_addsub_pipe

Two-stage pipelined modular adder/subtractor for the NTT butterfly datapath. Each accepted operand pair (a, b) produces both (a + b) mod Q and (a − b) mod Q. The block sits directly downstream of the bit-level adder cells. It replaces their raw sum/carry outputs with reduced residues that feed the butterfly output registers. A valid/ready handshake on both sides supports full throughput (one pair per cycle) and lossless backpressure.

## Interface
- WIDTH, 14, operand/result width in bits; Q < 2^WIDTH required.
- Q, 12289, modulus; must be odd and ≥ 3.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- a  input  WIDTH  first operand, expected in [0, Q−1].
- b  input  WIDTH  second operand, expected in [0, Q−1].
- out_valid  output  1  result pair present.
- out_ready  input  1  downstream accepts result this cycle.
- sum  output  WIDTH  (a + b) mod Q.
- diff  output  WIDTH  (a − b) mod Q.
- err  output  1  sticky flag: some accepted operand was ≥ Q.

## Operation
- Handshake rules:
  - Input transfer occurs on a rising edge with in_valid && in_ready.
  - Output transfer occurs on a rising edge with out_valid && out_ready.
- Stage 1 (registered on accept):
  - s1 = a + b, WIDTH+1 bits, no overflow loss.
  - d1 = {1'b0,a} − {1'b0,b}, WIDTH+1 bits; the MSB is the borrow.
  - v1 is set.
- Stage 2 (registered on advance):
  - sum = (s1 ≥ Q) ? s1 − Q : s1.
  - diff = borrow ? d1[WIDTH-1:0] + Q (truncated to WIDTH) : d1[WIDTH-1:0].
  - v2 is set.
- Advance logic:
  - Stage 2 loads when v1 && (!v2 || out_ready).
  - Stage 1 loads when in_valid && in_ready.
  - in_ready = !v1 || !v2 || out_ready, combinational.
- A stage with no incoming data clears its valid bit when its contents are consumed.
- Ordering is strict FIFO; no reordering, duplication or drop.
- err:
  - Set on the edge accepting a pair where a ≥ Q or b ≥ Q.
  - Cleared only by reset.
  - The pair is still processed; its results are unspecified but still emitted.
- Arithmetic is exact for all in-range inputs, with no multi-cycle reduction. One conditional subtract/add suffices because inputs are < Q.

## Timing
- Reset (async assert, sync release on clk):
  - v1 = v2 = 0, out_valid = 0, sum = 0, diff = 0, err = 0.
  - in_ready = 1 immediately after reset.
- Latency: a pair accepted at edge k appears with out_valid = 1 after edge k+1 (two register stages: edge k → stage 1, edge k+1 → stage 2), assuming no stall.
- Throughput: 1 pair/cycle with out_ready held high.
- Stall behaviour:
  - While out_valid && !out_ready, sum/diff/out_valid hold stable.
  - Stage 1 may still fill if empty.
  - Once both stages are full, in_ready = 0.
- Capacity: 2 pairs in flight.
- Full-stall release: when out_ready rises with both stages full, all of the following happen on the same edge:
  - Stage 2 takes stage 1.
  - Stage 1 takes a new input.
  - in_ready is already 1 that cycle.
- Simultaneous accept and emit with a single item in flight: both occur on the same edge; the pipeline stays half or fully occupied accordingly.
- Reset mid-operation discards all in-flight pairs. No output transfer occurs on the reset edge.

## Test plan
- Reset values:
  - Stimulus: assert rst_n = 0 mid-stream with 2 pairs in flight.
  - Required: out_valid = 0, sum = diff = 0, err = 0, in_ready = 1 immediately; nothing is emitted after release.
- Wrap cases (Q = 12289):
  - (12000, 500) → sum 211, diff 11500.
  - (5, 10) → sum 15, diff 12284.
  - (12288, 12288) → sum 12287, diff 0.
  - (0, 0) → 0, 0.
  - Each pair is emitted 2 edges after acceptance.
- Streaming:
  - Stimulus: 100 random in-range pairs back-to-back with out_ready = 1.
  - Required: one result per cycle, in order, matching a reference model; in_ready is never low.
- Backpressure:
  - Stimulus: send pairs 1, 2, 3 with out_ready = 0 for 4 cycles.
  - Required: in_ready = 0 after 2 pairs are held; output is stable at pair 1. After out_ready = 1, pairs 1, 2, 3 emerge on consecutive cycles.
- Invalid operand:
  - Stimulus: accept a = 12289, b = 1.
  - Required: err = 1 from the next edge and stays 1 through later valid traffic, until reset.
- Bubbles:
  - Stimulus: in_valid toggles every other cycle and out_ready is random.
  - Required: no lost or duplicated results; out_valid never asserts without a prior accept.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor: stage 1 forms the raw sum and
// borrow-extended difference, stage 2 reduces both into [0, Q-1].
module mod_addsub_pipe #(
    parameter int WIDTH = 14,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] diff,
    output logic             err
);

    localparam logic [WIDTH:0]   Q_EXT = (WIDTH + 1)'(Q);
    localparam logic [WIDTH-1:0] Q_W   = WIDTH'(Q);

    logic             v1_q, v1_d;
    logic [WIDTH:0]   s1_q, s1_d;
    logic [WIDTH:0]   d1_q, d1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             err_q, err_d;

    logic             accept;
    logic             advance;
    logic [WIDTH:0]   s1_minus_q;
    logic [WIDTH-1:0] sum_red;
    logic [WIDTH-1:0] diff_red;

    // Stage 2 frees up whenever it is empty or being drained, so stage 1 can
    // always hand over and take a new pair in the same cycle.
    always_comb begin
        in_ready = !v1_q || !v2_q || out_ready;
        accept   = in_valid && in_ready;
        advance  = v1_q && (!v2_q || out_ready);
    end

    // Inputs are < Q, so one conditional correction fully reduces either result.
    always_comb begin
        s1_minus_q = s1_q - Q_EXT;
        sum_red    = (s1_q >= Q_EXT) ? s1_minus_q[WIDTH-1:0] : s1_q[WIDTH-1:0];
        diff_red   = d1_q[WIDTH] ? (d1_q[WIDTH-1:0] + Q_W) : d1_q[WIDTH-1:0];
    end

    // NOTE: every output of a combinational block gets a default first; a
    // path that skips an assignment would otherwise infer a latch.
    always_comb begin
        v1_d   = v1_q;
        s1_d   = s1_q;
        d1_d   = d1_q;
        v2_d   = v2_q;
        sum_d  = sum_q;
        diff_d = diff_q;
        err_d  = err_q;

        if (accept) begin
            v1_d = 1'b1;
            s1_d = {1'b0, a} + {1'b0, b};
            d1_d = {1'b0, a} - {1'b0, b};
            if (a >= Q_W || b >= Q_W) begin
                err_d = 1'b1;
            end
        end else if (advance) begin
            v1_d = 1'b0;
        end

        if (advance) begin
            v2_d   = 1'b1;
            sum_d  = sum_red;
            diff_d = diff_red;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge value. The data registers are reset too because sum/diff
    // are directly visible and must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            s1_q   <= '0;
            d1_q   <= '0;
            v2_q   <= 1'b0;
            sum_q  <= '0;
            diff_q <= '0;
            err_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            d1_q   <= d1_d;
            v2_q   <= v2_d;
            sum_q  <= sum_d;
            diff_q <= diff_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign diff      = diff_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: scoreboard of expected residues,
// directed wrap/backpressure/error/reset steps plus random streaming and bubbles.
module tb_mod_addsub_pipe;

    localparam int WIDTH = 14;
    localparam int Q     = 12289;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] d;
        bit               dc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod_addsub_pipe #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .diff      (diff),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: plain integer modular arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
        exp_t e;
        int   ia;
        int   ib;
        ia   = int'(xa);
        ib   = int'(xb);
        e.dc = (ia >= Q) || (ib >= Q);
        e.s  = WIDTH'((ia + ib) % Q);
        e.d  = WIDTH'((ia - ib + Q) % Q);
        return e;
    endfunction

    // Handshakes are sampled on the falling edge; the transfer they describe
    // happens on the following rising edge.
    initial begin
        logic             prev_stall;
        logic [WIDTH-1:0] prev_sum;
        logic [WIDTH-1:0] prev_diff;
        exp_t             e;
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_diff  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(out_valid), 32'd1);
                    check("stall_hold_sum", 32'(sum), 32'(prev_sum));
                    check("stall_hold_diff", 32'(diff), 32'(prev_diff));
                end
                if (out_valid) begin
                    check("no_phantom_output", 32'(sb.size() != 0), 32'd1);
                    if (out_ready && sb.size() != 0) begin
                        e = sb.pop_front();
                        if (!e.dc) begin
                            check("sb_sum", 32'(sum), 32'(e.s));
                            check("sb_diff", 32'(diff), 32'(e.d));
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(model(a, b));
                end
                prev_stall = out_valid && !out_ready;
                prev_sum   = sum;
                prev_diff  = diff;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the run completed");
        $fatal(1, "watchdog");
    end

    // Presents a pair and waits (bounded) for it to be accepted; in_valid is
    // left high so back-to-back calls stream without bubbles.
    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, output int waited);
        bit done;
        done     = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        while (!done && waited < 50) begin
            @(negedge clk);
            waited++;
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic wrap_case(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                             input logic [WIDTH-1:0] es, input logic [WIDTH-1:0] ed);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        @(negedge clk);
        check("wrap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("wrap_latency_stage1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("wrap_latency_stage2", 32'(out_valid), 32'd1);
        check("wrap_sum", 32'(sum), 32'(es));
        check("wrap_diff", 32'(diff), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        wrap_case(14'd12000, 14'd500, 14'd211, 14'd11500);
        wrap_case(14'd5, 14'd10, 14'd15, 14'd12284);
        wrap_case(14'd12288, 14'd12288, 14'd12287, 14'd0);
        wrap_case(14'd0, 14'd0, 14'd0, 14'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(WIDTH'($urandom_range(Q - 1)), WIDTH'($urandom_range(Q - 1)), w);
            check("stream_one_per_cycle", 32'(w), 32'd1);
            if (i > 0) check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stream_drained", 32'(sb.size()), 32'd0);

        out_ready = 1'b0;
        send(14'd100, 14'd200, w);
        send(14'd7, 14'd3, w);
        in_valid = 1'b1;
        a        = 14'd12288;
        b        = 14'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum_p1", 32'(sum), 32'd300);
            check("bp_diff_p1", 32'(diff), 32'd12189);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_sum_p1", 32'(sum), 32'd300);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_p2_valid", 32'(out_valid), 32'd1);
        check("bp_p2_sum", 32'(sum), 32'd10);
        check("bp_p2_diff", 32'(diff), 32'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_p3_valid", 32'(out_valid), 32'd1);
        check("bp_p3_sum", 32'(sum), 32'd0);
        check("bp_p3_diff", 32'(diff), 32'd12287);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        check("err_before_invalid", 32'(err), 32'd0);
        send(14'd12289, 14'd1, w);
        in_valid = 1'b0;
        check("err_set", 32'(err), 32'd1);
        send(14'd1, 14'd2, w);
        send(14'd3, 14'd4, w);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("err_held_after_traffic", 32'(err), 32'd1);

        for (int i = 0; i < 80; i++) begin
            in_valid  = (i % 2 == 0);
            a         = WIDTH'($urandom_range(Q - 1));
            b         = WIDTH'($urandom_range(Q - 1));
            out_ready = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bubble_drained", 32'(sb.size()), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        out_ready = 1'b0;
        send(14'd11, 14'd22, w);
        send(14'd33, 14'd44, w);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_diff", 32'(diff), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_no_output", 32'(out_valid), 32'd0);
            check("post_reset_in_ready", 32'(in_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
